// File: rtl/ariane_pkg.sv
// Shared front-end types for the branch predictors.
//   VLEN / INSTR_PER_FETCH : virtual address width and slots per fetch block
//   GHR_LENGTH             : default global-history length for the perceptron predictor
//   bht_prediction_t       : per-slot prediction (valid, taken)
//   perceptron_update_t    : resolved-branch training packet, carries the history
//                            snapshot that was used when the branch was predicted
package ariane_pkg;

    localparam int unsigned VLEN            = 64;
    localparam int unsigned INSTR_PER_FETCH = 2;
    localparam int unsigned GHR_LENGTH      = 16;

    typedef struct packed {
        logic valid;
        logic taken;
    } bht_prediction_t;

    typedef struct packed {
        logic                  valid;
        logic [VLEN-1:0]       pc;
        logic                  taken;
        logic                  mispredict;
        logic [GHR_LENGTH-1:0] ghr;
    } perceptron_update_t;

endpackage

// File: rtl/perceptron_dot.sv
// One perceptron: signed dot product of weights against the history plus bias,
// and the saturating +/-1 adjustment of every weight for a given outcome.
//   hist       : history bits (1 adds the weight, 0 subtracts it)
//   entry      : {bias, w[GHR_LENGTH-1], ..., w[0]}, each WEIGHT_BITS two's complement
//   taken      : outcome used to build entry_next
//   sum        : signed SUMW-bit sum, wide enough that it never overflows
//   entry_next : entry after one training step
module perceptron_dot #(
    parameter int unsigned GHR_LENGTH  = 16,
    parameter int unsigned WEIGHT_BITS = 8,
    parameter int unsigned SUMW        = WEIGHT_BITS + $clog2(GHR_LENGTH + 1) + 1
) (
    input  logic [GHR_LENGTH-1:0]                 hist,
    input  logic [(GHR_LENGTH+1)*WEIGHT_BITS-1:0] entry,
    input  logic                                  taken,
    output logic [SUMW-1:0]                       sum,
    output logic [(GHR_LENGTH+1)*WEIGHT_BITS-1:0] entry_next
);

    // Weights are clamped symmetrically, so the most negative code is never used.
    localparam logic [WEIGHT_BITS-1:0] WMAX = {1'b0, {(WEIGHT_BITS-1){1'b1}}};
    localparam logic [WEIGHT_BITS-1:0] WMIN = -WMAX;

    function automatic logic [SUMW-1:0] sext(input logic [WEIGHT_BITS-1:0] w);
        return {{(SUMW-WEIGHT_BITS){w[WEIGHT_BITS-1]}}, w};
    endfunction

    function automatic logic [WEIGHT_BITS-1:0] sat_step(input logic [WEIGHT_BITS-1:0] w,
                                                         input logic up);
        if (up) return (w == WMAX) ? w : w + 1'b1;
        else    return (w == WMIN) ? w : w - 1'b1;
    endfunction

    logic [SUMW-1:0] acc;

    always_comb begin
        acc        = sext(entry[GHR_LENGTH*WEIGHT_BITS +: WEIGHT_BITS]);
        entry_next = '0;
        entry_next[GHR_LENGTH*WEIGHT_BITS +: WEIGHT_BITS] =
            sat_step(entry[GHR_LENGTH*WEIGHT_BITS +: WEIGHT_BITS], taken);
        for (int j = 0; j < GHR_LENGTH; j++) begin
            if (hist[j]) acc = acc + sext(entry[j*WEIGHT_BITS +: WEIGHT_BITS]);
            else         acc = acc - sext(entry[j*WEIGHT_BITS +: WEIGHT_BITS]);
            entry_next[j*WEIGHT_BITS +: WEIGHT_BITS] =
                sat_step(entry[j*WEIGHT_BITS +: WEIGHT_BITS], taken == hist[j]);
        end
    end

    assign sum = acc;

endmodule

// File: rtl/perceptron_bp.sv
// Global-history perceptron branch predictor for a multi-slot fetch block.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   flush_i        : restart the table clear (INIT) and drop history / pending write
//   debug_mode_i   : freeze history and ignore updates; predictions keep flowing
//   is_branch_i    : per-slot branch flags for the block at vpc_i
//   vpc_i          : fetch-block PC
//   update_i       : resolved branch used for training / history repair
//   prediction_o   : per-slot valid/taken, combinational from table and ghr_q
//   ghr_o          : speculative history used for this cycle's prediction
//   ready_o        : table has been cleared and predictions are live
// Training is two-stage: stage 1 reads and computes new weights, stage 2 writes.
module perceptron_bp #(
    parameter int unsigned GHR_LENGTH      = ariane_pkg::GHR_LENGTH,
    parameter int unsigned NR_ENTRIES      = 256,
    parameter int unsigned WEIGHT_BITS     = 8,
    parameter int unsigned TRAIN_THRESHOLD = 45
) (
    input  logic                                                   clk_i,
    input  logic                                                   rst_ni,
    input  logic                                                   flush_i,
    input  logic                                                   debug_mode_i,
    input  logic [ariane_pkg::INSTR_PER_FETCH-1:0]                 is_branch_i,
    input  logic [ariane_pkg::VLEN-1:0]                            vpc_i,
    input  ariane_pkg::perceptron_update_t                         update_i,
    output ariane_pkg::bht_prediction_t [ariane_pkg::INSTR_PER_FETCH-1:0] prediction_o,
    output logic [GHR_LENGTH-1:0]                                  ghr_o,
    output logic                                                   ready_o
);

    localparam int unsigned IPF    = ariane_pkg::INSTR_PER_FETCH;
    localparam int unsigned OFFSET = 1 + $clog2(IPF);
    localparam int unsigned IDX    = $clog2(NR_ENTRIES);
    localparam int unsigned SLOTW  = $clog2(IPF);
    localparam int unsigned EW     = (GHR_LENGTH + 1) * WEIGHT_BITS;
    localparam int unsigned SUMW   = WEIGHT_BITS + $clog2(GHR_LENGTH + 1) + 1;
    localparam int unsigned HW     = (GHR_LENGTH > IDX) ? GHR_LENGTH : IDX;
    localparam logic signed [SUMW-1:0] THR = SUMW'(TRAIN_THRESHOLD);

    localparam logic [0:0] INIT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    // Row hash: PC index bits XOR low history bits (history zero-extended if short).
    function automatic logic [IDX-1:0] row_of(input logic [IDX-1:0]        pc_bits,
                                              input logic [GHR_LENGTH-1:0] hist);
        logic [HW-1:0] hist_ext;
        hist_ext = HW'(hist);
        return pc_bits ^ hist_ext[IDX-1:0];
    endfunction

    logic [0:0]            state_q, state_d;
    logic [IDX-1:0]        cnt_q, cnt_d;
    logic [GHR_LENGTH-1:0] ghr_q, ghr_d, ghr_spec;
    logic [EW-1:0]         table_q [NR_ENTRIES][IPF];

    logic                  s2_valid_q;
    logic [IDX-1:0]        s2_row_q;
    logic [SLOTW-1:0]      s2_slot_q;
    logic [EW-1:0]         s2_entry_q;

    assign ready_o = (state_q == RUN);
    assign ghr_o   = ghr_q;

    // ---------------- prediction ----------------
    logic [IDX-1:0]           pred_row;
    logic [IPF-1:0][SUMW-1:0] pred_sum;
    logic [IPF-1:0][EW-1:0]   pred_next_unused;
    logic [IPF-1:0]           pred_taken;

    assign pred_row = row_of(vpc_i[OFFSET+IDX-1:OFFSET], ghr_q);

    for (genvar i = 0; i < IPF; i++) begin : g_pred
        perceptron_dot #(
            .GHR_LENGTH (GHR_LENGTH),
            .WEIGHT_BITS(WEIGHT_BITS),
            .SUMW       (SUMW)
        ) u_dot (
            .hist      (ghr_q),
            .entry     (table_q[pred_row][i]),
            .taken     (1'b0),
            .sum       (pred_sum[i]),
            .entry_next(pred_next_unused[i])
        );
        assign prediction_o[i].valid = ready_o & is_branch_i[i];
        assign prediction_o[i].taken = ready_o & is_branch_i[i] & ~pred_sum[i][SUMW-1];
        assign pred_taken[i]         = prediction_o[i].taken;
    end

    // ---------------- training stage 1 ----------------
    logic [IDX-1:0]   upd_row;
    logic [SLOTW-1:0] upd_slot;
    logic             upd_fire, upd_train, upd_fwd;
    logic [EW-1:0]    upd_entry, upd_next;
    logic [SUMW-1:0]  upd_sum;

    assign upd_row  = row_of(update_i.pc[OFFSET+IDX-1:OFFSET], update_i.ghr[GHR_LENGTH-1:0]);
    assign upd_slot = update_i.pc[OFFSET-1:1];
    assign upd_fire = update_i.valid & ready_o & ~debug_mode_i;

    // A write still in stage 2 has not reached the table yet; take it from the register.
    assign upd_fwd   = s2_valid_q && (s2_row_q == upd_row) && (s2_slot_q == upd_slot);
    assign upd_entry = upd_fwd ? s2_entry_q : table_q[upd_row][upd_slot];

    perceptron_dot #(
        .GHR_LENGTH (GHR_LENGTH),
        .WEIGHT_BITS(WEIGHT_BITS),
        .SUMW       (SUMW)
    ) u_train (
        .hist      (update_i.ghr[GHR_LENGTH-1:0]),
        .entry     (upd_entry),
        .taken     (update_i.taken),
        .sum       (upd_sum),
        .entry_next(upd_next)
    );

    assign upd_train = update_i.mispredict |
                       (($signed(upd_sum) <= THR) && ($signed(upd_sum) >= -THR));

    // ---------------- FSM and history ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == IDX'(NR_ENTRIES - 1)) state_d = RUN;
        end
    end

    // Every slot sums against the pre-shift ghr_q; the shifts chain in slot order.
    always_comb begin
        ghr_spec = ghr_q;
        for (int i = 0; i < IPF; i++) begin
            if (is_branch_i[i]) ghr_spec = {ghr_spec[GHR_LENGTH-2:0], pred_taken[i]};
        end
        ghr_d = ghr_spec;
        if (state_q == INIT)                               ghr_d = '0;
        else if (debug_mode_i)                             ghr_d = ghr_q;
        else if (update_i.valid && update_i.mispredict)
            ghr_d = {update_i.ghr[GHR_LENGTH-2:0], update_i.taken};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= INIT;
            cnt_q      <= '0;
            ghr_q      <= '0;
            s2_valid_q <= 1'b0;
        end else if (flush_i) begin
            state_q    <= INIT;
            cnt_q      <= '0;
            ghr_q      <= '0;
            s2_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ghr_q      <= ghr_d;
            s2_valid_q <= upd_fire & upd_train;
        end
    end

    always_ff @(posedge clk_i) begin
        if (upd_fire) begin
            s2_row_q   <= upd_row;
            s2_slot_q  <= upd_slot;
            s2_entry_q <= upd_next;
        end
    end

    // ---------------- table (stage 2 write / INIT clear) ----------------
    always_ff @(posedge clk_i) begin
        if (state_q == INIT) begin
            for (int s = 0; s < IPF; s++) table_q[cnt_q][s] <= '0;
        end else if (s2_valid_q) begin
            table_q[s2_row_q][s2_slot_q] <= s2_entry_q;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{vpc_i, update_i};

endmodule

// File: tb/tb_perceptron_bp.sv
// Directed bench for perceptron_bp: reset/INIT timing, training thresholds,
// stage-2 forwarding, speculative history, mispredict repair, debug freeze,
// flush restart, and weight saturation on a 4-bit-weight instance.
module tb_perceptron_bp;
    import ariane_pkg::*;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic                             rst_n, flush, debug;
    logic [INSTR_PER_FETCH-1:0]       is_branch;
    logic [VLEN-1:0]                  vpc;
    perceptron_update_t               upd, upd4;
    bht_prediction_t [INSTR_PER_FETCH-1:0] pred, pred4;
    logic [GHR_LENGTH-1:0]            ghr, ghr4;
    logic                             ready, ready4;

    int         n_assert;
    int         n_fail;
    logic       seen;
    logic [7:0] exp_bias_seq [5];

    perceptron_bp u_dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .debug_mode_i(debug),
        .is_branch_i (is_branch),
        .vpc_i       (vpc),
        .update_i    (upd),
        .prediction_o(pred),
        .ghr_o       (ghr),
        .ready_o     (ready)
    );

    perceptron_bp #(.NR_ENTRIES(16), .WEIGHT_BITS(4)) u_dut4 (
        .clk_i       (clk_i),
        .rst_ni      (rst_n),
        .flush_i     (1'b0),
        .debug_mode_i(1'b0),
        .is_branch_i ('0),
        .vpc_i       ('0),
        .update_i    (upd4),
        .prediction_o(pred4),
        .ghr_o       (ghr4),
        .ready_o     (ready4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_upd(input logic [63:0] pc, input logic taken, input logic mis,
                            input logic [15:0] h);
        upd.valid      = 1'b1;
        upd.pc         = pc;
        upd.taken      = taken;
        upd.mispredict = mis;
        upd.ghr        = h;
    endtask

    function automatic logic [7:0] bias_main(input int r, input int s);
        logic [17*8-1:0] e;
        e = u_dut.table_q[r][s];
        return e[16*8 +: 8];
    endfunction

    function automatic logic [7:0] w0_main(input int r, input int s);
        logic [17*8-1:0] e;
        e = u_dut.table_q[r][s];
        return e[7:0];
    endfunction

    function automatic logic [3:0] bias_4(input int r, input int s);
        logic [17*4-1:0] e;
        e = u_dut4.table_q[r][s];
        return e[16*4 +: 4];
    endfunction

    function automatic logic [3:0] w0_4(input int r, input int s);
        logic [17*4-1:0] e;
        e = u_dut4.table_q[r][s];
        return e[3:0];
    endfunction

    initial begin
        n_assert = 0;
        n_fail   = 0;
        exp_bias_seq = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3};
        rst_n = 1'b0; flush = 1'b0; debug = 1'b0;
        is_branch = 2'b11; vpc = '0; upd = '0; upd4 = '0;
        #2;
        check("rst_ready", ready, 0);
        check("rst_pred", pred, 0);
        check("rst_ghr", ghr, 0);
        check("rst_state", u_dut.state_q, 0);

        // Reset release: 256 clears, then ready.
        @(negedge clk_i);
        @(negedge clk_i);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 1; k <= 255; k++) begin
            tick();
            seen = seen | ready | pred[0].valid | pred[1].valid;
        end
        check("init_ready_low_255", seen, 0);
        tick();
        check("ready_at_256", ready, 1);
        check("ghr_after_init", ghr, 0);
        check("pred_first_run", pred, 4'hF);
        is_branch = 2'b00;

        // Repeated taken updates, no mispredict: bias 1,2,3 then y=51 stops training.
        for (int k = 0; k < 5; k++) begin
            send_upd(64'h124, 1'b1, 1'b0, 16'h0000);
            tick();
            upd.valid = 1'b0;
            tick();
            check($sformatf("bias_train_%0d", k), bias_main(73, 0), exp_bias_seq[k]);
        end
        check("w0_after_train", w0_main(73, 0), 8'hFD);
        check("ghr_no_mispredict", ghr, 0);

        // Back-to-back updates to row 73 slot 1: forwarded, bias ends at 2.
        send_upd(64'h126, 1'b1, 1'b0, 16'h0000);
        tick();
        tick();
        check("b2b_first_write", bias_main(73, 1), 8'd1);
        upd.valid = 1'b0;
        tick();
        check("b2b_forwarded", bias_main(73, 1), 8'd2);

        // Make row 32 slot 1 predict not-taken (y = -17), slot 0 stays taken (y = 0).
        send_upd(64'h82, 1'b0, 1'b0, 16'h0000);
        tick();
        upd.valid = 1'b0;
        tick();
        check("slot1_bias_neg", bias_main(32, 1), 8'hFF);
        vpc = 64'h80;
        is_branch = 2'b11;
        #1;
        check("pred_taken_nottaken", pred, 4'b1011);
        tick();
        check("ghr_spec_shift", ghr, 16'h0002);

        // Mispredict repair overrides the speculative shift in the same cycle.
        send_upd(64'h300, 1'b1, 1'b1, 16'h00FF);
        tick();
        check("ghr_mispredict_override", ghr, 16'h01FF);
        upd.valid = 1'b0;
        is_branch = 2'b00;
        tick();

        // Debug mode: predictions continue, history and table frozen.
        debug = 1'b1;
        is_branch = 2'b11;
        vpc = 64'h80;
        #1;
        check("dbg_pred_driven", pred, 4'hF);
        send_upd(64'h124, 1'b1, 1'b1, 16'h0000);
        tick();
        tick();
        check("dbg_ghr_frozen", ghr, 16'h01FF);
        check("dbg_table_frozen", bias_main(73, 0), 8'd3);
        upd.valid = 1'b0;
        debug = 1'b0;
        is_branch = 2'b00;

        // Flush from RUN, then flush again at cnt_q = 100.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_ready_low", ready, 0);
        check("flush_ghr_clear", ghr, 0);
        check("flush_cnt_zero", u_dut.cnt_q, 0);
        tick_n(100);
        check("init_cnt_100", u_dut.cnt_q, 100);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("reflush_cnt_zero", u_dut.cnt_q, 0);
        seen = 1'b0;
        for (int k = 1; k <= 255; k++) begin
            tick();
            seen = seen | ready;
        end
        check("reflush_ready_low_255", seen, 0);
        tick();
        check("reflush_ready_at_256", ready, 1);
        check("table_cleared", bias_main(73, 0), 8'd0);

        // 4-bit weights with forced mispredict: bias saturates at 7, weights at -7.
        check("dut4_ready", ready4, 1);
        for (int k = 1; k <= 10; k++) begin
            upd4.valid = 1'b1; upd4.pc = 64'h10; upd4.taken = 1'b1;
            upd4.mispredict = 1'b1; upd4.ghr = 16'h0000;
            tick();
            upd4.valid = 1'b0;
            tick();
            check($sformatf("sat_bias_%0d", k), bias_4(4, 0), (k > 7) ? 7 : k);
        end
        check("sat_w0", w0_4(4, 0), 4'h9);
        check("dut4_ghr", ghr4, 16'h0001);
        check("dut4_pred_idle", pred4, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/perceptron_bp.md
PERCEPTRON_BP -- requirements
Module: perceptron_bp

Interface
REQ-001 SHALL have parameters: GHR_LENGTH (default 16, global history bits); NR_ENTRIES (default 256, rows, power of 2); WEIGHT_BITS (default 8, signed weight/bias width); TRAIN_THRESHOLD (default 45, training margin).
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  restart table clear.
- debug_mode_i  in  1  freeze history, drop updates.
- is_branch_i  in  INSTR_PER_FETCH  per-slot branch in fetch block.
- vpc_i  in  VLEN  fetch-block PC.
- update_i  in  perceptron_update_t  resolved branch: valid, pc, taken, mispredict, ghr snapshot.
- prediction_o  out  bht_prediction_t[INSTR_PER_FETCH]  per-slot valid/taken.
- ghr_o  out  GHR_LENGTH  speculative history used for this cycle's prediction.
- ready_o  out  1  table initialised.

Function
REQ-003 SHALL derive OFFSET = 1 + clog2(INSTR_PER_FETCH) and IDX = clog2(NR_ENTRIES).
REQ-004 SHALL compute the prediction row as vpc_i[OFFSET+IDX-1:OFFSET] XOR ghr_q[IDX-1:0], with the history zero-extended when GHR_LENGTH < IDX.
REQ-005 SHALL compute the update row the same way from update_i.pc and update_i.ghr; the update slot is update_i.pc[OFFSET-1:1].
REQ-006 SHALL compute per-slot sum y = bias + sum over j of (h[j] ? +w[j] : -w[j]), in signed width SUMW = WEIGHT_BITS + clog2(GHR_LENGTH+1) + 1; no overflow is possible.
REQ-007 SHALL drive prediction_o[i].valid = ready_o & is_branch_i[i] and prediction_o[i].taken = valid & (y >= 0), combinationally from the registered table and ghr_q.
REQ-008 SHALL update the speculative history each cycle with no mispredict and no debug mode: for each slot i in ascending order with is_branch_i[i], shift left and insert prediction_o[i].taken. All slots use the pre-shift ghr_q for their sums.
REQ-009 On update_i.valid & mispredict, SHALL set ghr_d = {update_i.ghr[GHR_LENGTH-2:0], update_i.taken}; this overrides REQ-008 in the same cycle.
REQ-010 Training, stage 1 (cycle N, update_i.valid & ready_o & !debug_mode_i):
- read row/slot, with forwarding from a pending stage-2 write to the same row/slot;
- compute y from update_i.ghr;
- train = mispredict | (|y| <= TRAIN_THRESHOLD);
- register row, slot, new weights and train.
REQ-011 Training, stage 2 (cycle N+1): if train, write the weights:
- w[j] += (taken == ghr[j]) ? +1 : -1;
- bias += taken ? +1 : -1;
- all values saturate at +/-(2^(WEIGHT_BITS-1)-1);
- result visible to predictions from cycle N+2.
REQ-012 SHALL run an FSM with states INIT and RUN:
- INIT: writes row cnt_q with all-zero weights/bias each cycle, increments cnt_q, goes to RUN after row NR_ENTRIES-1; ready_o=0; updates dropped; ghr held at 0.
- RUN: ready_o=1.
REQ-013 flush_i in any state SHALL, next cycle, force INIT with cnt_q=0, ghr_q=0, and cancel any pending stage-2 write.
REQ-014 debug_mode_i SHALL hold ghr_q and drop updates; predictions continue.
REQ-015 The table SHALL have no reset; it is cleared only by INIT.

Reset
REQ-016 Asserting rst_ni SHALL set: state=INIT, cnt_q=0, ghr_q=0, stage-2 valid=0.
REQ-017 Outputs during reset SHALL be: prediction_o all 0, ready_o=0, ghr_o=0. ready_o SHALL rise exactly NR_ENTRIES cycles after reset release.

Structure
REQ-018 perceptron_update_t and the GHR_LENGTH default SHALL live in ariane_pkg, alongside bht_prediction_t.
REQ-019 The per-slot dot-product/saturating-adjust SHALL be a sub-module, perceptron_dot, instantiated INSTR_PER_FETCH times for prediction and once for training.

Verification
REQ-020 Reset release with NR_ENTRIES=256 -> ready_o=0 for 256 cycles, then 1; all is_branch_i predictions before that have valid=0.
REQ-021 Repeated taken updates to one PC (ghr=0, mispredict=0) -> bias goes 1,2,3..., and training stops once |y| > 45; with WEIGHT_BITS=4 and mispredict=1 forced, bias saturates at 7.
REQ-022 Back-to-back updates to the same row/slot in cycles N and N+1 -> stage-1 forwarding applies, and bias advances by 2, not 1.
REQ-023 is_branch_i=2'b11 with predictions taken/not-taken, ghr_q=0 -> ghr_q next = ...0010; a simultaneous mispredict with ghr=0x00FF, taken=1 -> ghr_q=0x01FF.
REQ-024 flush_i asserted mid-INIT at cnt_q=100 -> INIT restarts at 0; ready_o rises 256 cycles after the flush.
REQ-025 debug_mode_i=1 with valid updates and branches -> ghr_q and table unchanged; prediction_o still driven.
